// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states
// and the alignment rule used when a request is accepted.
package load_store_unit_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } lsu_size_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        RMW_READ = 3'd2,
        WRITE    = 3'd3,
        RESP     = 3'd4
    } lsu_state_t;

    // Reserved size counts as misaligned so one check covers both faults.
    function automatic logic is_misaligned(input lsu_size_t size, input logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = offset[0];
            SIZE_WORD: bad = |offset;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane steering: extracts and extends load data from a memory
// word, and merges sub-word store data into the previously read word.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  lsu_size_t        size,
    input  logic [1:0]       offset,
    input  logic             is_unsigned,
    input  logic [XLEN-1:0]  rd_word,
    input  logic [XLEN-1:0]  old_word,
    input  logic [XLEN-1:0]  wdata,
    output logic [XLEN-1:0]  load_data_c,
    output logic [XLEN-1:0]  store_data_c
);

    logic [4:0]      shamt;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;

    always_comb begin
        shamt        = 5'd0;
        mask         = '1;
        load_data_c  = rd_word;
        store_data_c = wdata;

        case (size)
            SIZE_BYTE: begin
                shamt = {offset, 3'b000};
                mask  = 32'h0000_00FF << shamt;
            end
            SIZE_HALF: begin
                shamt = {offset[1], 4'b0000};
                mask  = 32'h0000_FFFF << shamt;
            end
            default: begin
                shamt = 5'd0;
                mask  = '1;
            end
        endcase

        shifted = rd_word >> shamt;

        case (size)
            SIZE_BYTE: load_data_c = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            SIZE_HALF: load_data_c = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            default:   load_data_c = rd_word;
        endcase

        // Word stores have an all-ones mask, so the merge degenerates to wdata.
        store_data_c = (old_word & ~mask) | ((wdata << shamt) & mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: accepts one request at a time, performs
// byte/half/word loads and stores (sub-word stores via read-modify-write)
// against a word-addressed memory, and reports faulting accesses.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_is_store,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [XLEN-1:0]  req_addr,
    input  logic [XLEN-1:0]  req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_rdata,
    output logic             resp_fault,
    output logic             mem_write_enable,
    output logic [XLEN-1:0]  mem_address,
    output logic [XLEN-1:0]  mem_write_data,
    input  logic [XLEN-1:0]  mem_read_data
);

    localparam logic [XLEN:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

    lsu_state_t      state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    lsu_size_t       size_q, size_d;
    logic            unsigned_q, unsigned_d;
    logic [XLEN-1:0] old_q, old_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            fault_q, fault_d;

    logic            req_fault_c;
    logic [XLEN-1:0] load_data_c;
    logic [XLEN-1:0] store_data_c;

    lsu_lane_align u_lane_align (
        .size         (size_q),
        .offset       (addr_q[1:0]),
        .is_unsigned  (unsigned_q),
        .rd_word      (mem_read_data),
        .old_word     (old_q),
        .wdata        (wdata_q),
        .load_data_c  (load_data_c),
        .store_data_c (store_data_c)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= SIZE_BYTE;
            unsigned_q <= 1'b0;
            old_q      <= '0;
            rdata_q    <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            old_q      <= old_d;
            rdata_q    <= rdata_d;
            fault_q    <= fault_d;
        end
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        old_d       = old_q;
        rdata_d     = rdata_q;
        fault_d     = fault_q;
        req_fault_c = is_misaligned(lsu_size_t'(req_size), req_addr[1:0])
                    | ({1'b0, req_addr} >= ADDR_LIMIT);

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    size_d     = lsu_size_t'(req_size);
                    unsigned_d = req_unsigned;
                    old_d      = '0;
                    rdata_d    = '0;
                    fault_d    = req_fault_c;
                    if (req_fault_c) begin
                        state_d = RESP;
                    end else if (req_is_store) begin
                        state_d = (size_d == SIZE_WORD) ? WRITE : RMW_READ;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                rdata_d = load_data_c;
                state_d = RESP;
            end
            RMW_READ: begin
                old_d   = mem_read_data;
                state_d = WRITE;
            end
            WRITE: begin
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    rdata_d = '0;
                    fault_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory port is decoded from state so read data is usable in the same cycle.
    always_comb begin
        req_ready        = (state_q == IDLE);
        resp_valid       = (state_q == RESP);
        resp_rdata       = rdata_q;
        resp_fault       = fault_q;
        mem_write_enable = (state_q == WRITE);
        mem_address      = '0;
        mem_write_data   = '0;
        if (state_q == LOAD || state_q == RMW_READ || state_q == WRITE) begin
            mem_address = {addr_q[XLEN-1:2], 2'b00};
        end
        if (state_q == WRITE) begin
            mem_write_data = store_data_c;
        end
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage block directly upstream of the data memory unit. It accepts load/store requests from the pipeline over a valid/ready handshake and drives the memory's word-addressed port.
- Handles byte/halfword/word access. Sub-word stores use read-modify-write; loads use sign/zero extension.
- Detects misaligned and out-of-range accesses and reports them as faults with no memory side effects.
- Memory is little-endian: byte 0 is bits [7:0].

Parameters:
- MEM_WORDS, 64, number of 32-bit words in the data memory. A byte address >= MEM_WORDS*4 is out of range.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_is_store  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response available
- resp_ready  in  1  consumer takes the response
- resp_rdata  out  32  extended load data; 0 for stores and faults
- resp_fault  out  1  misaligned, out of range, or reserved size
- mem_write_enable  out  1  to data memory
- mem_address  out  32  word-aligned byte address to memory, bits [1:0] = 00
- mem_write_data  out  32  full word to write
- mem_read_data  in  32  combinational read data from memory

Behaviour:
- Reset values:
  - FSM = IDLE.
  - req_ready = 1 (combinational from IDLE).
  - resp_valid = 0, resp_rdata = 0, resp_fault = 0.
  - mem_write_enable = 0, mem_address = 0, mem_write_data = 0.
  - All internal registers = 0.
- States: IDLE, LOAD, RMW_READ, WRITE, RESP.
- Handshake:
  - req_ready = (state == IDLE).
  - Accept when req_valid & req_ready in cycle T. All request fields are registered at T.
- Fault check at accept:
  - Fault if size == 11.
  - Fault if half and addr[0] != 0.
  - Fault if word and addr[1:0] != 00.
  - Fault if addr >= MEM_WORDS*4.
  - Faulting request goes IDLE -> RESP at T+1 with resp_fault = 1, resp_rdata = 0. No memory write ever occurs.
- Load: IDLE -> LOAD (T+1) -> RESP (T+2).
  - In LOAD, mem_address = {addr_q[31:2], 2'b00}.
  - Select the byte/half by addr_q[1:0] from mem_read_data, extend per req_unsigned, register into resp_rdata.
- Word store: IDLE -> WRITE (T+1) -> RESP (T+2).
  - In WRITE, mem_write_enable = 1 and mem_write_data = wdata_q.
- Sub-word store: IDLE -> RMW_READ (T+1) -> WRITE (T+2) -> RESP (T+3).
  - In RMW_READ, capture mem_read_data into old_q.
  - In WRITE, write old_q with the selected lane replaced by wdata_q[7:0] or wdata_q[15:0]. Lane = addr_q[1:0] for bytes, addr_q[1] for halves.
- mem_write_enable is high only in WRITE, for exactly one cycle per store.
- mem_address holds the registered word address in LOAD, RMW_READ and WRITE; otherwise 0.
- RESP:
  - resp_valid = 1 and outputs are held stable until resp_ready.
  - On resp_ready, go to IDLE.
  - No new request is accepted in the same cycle, so back-to-back throughput is at most one request per 3 cycles.
- Reset mid-operation: async return to IDLE and all outputs to reset values. A store in RMW_READ is abandoned with no write. A store in WRITE may or may not complete depending on clock/reset timing; the bench must not check memory after reset is asserted in WRITE.
- req_valid while busy is ignored; the requester holds its request (standard valid/ready).

Decomposition:
- Shared package:
  - Size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD/SIZE_RSVD.
  - State enum lsu_state_t.
  - Function for the alignment check.
- One natural sub-module: lsu_lane_align, purely combinational, shared by both paths:
  - Load extract + sign/zero extension.
  - Store merge (old word, new data, size, offset -> merged word).

Test Plan:
- Word store then load: SW 0xDEADBEEF @0x10, then LW @0x10 -> one write at word 4 with data 0xDEADBEEF; load resp_rdata = 0xDEADBEEF, resp_fault = 0, resp_valid at T+2.
- Byte store merge: mem[4] = 0x11223344, SB 0xAA @0x12 -> write 0x11AA3344 at T+2, resp at T+3. Then LB @0x12 -> 0xFFFFFFAA; LBU @0x12 -> 0x000000AA.
- Halfword: mem[5] = 0, SH 0x8001 @0x16 -> mem[5] = 0x80010000. LH @0x16 -> 0xFFFF8001; LHU -> 0x00008001.
- Faults: LW @0x11, SH @0x13, size 11, and SW @0x100 (MEM_WORDS = 64) -> each gives resp_fault = 1, rdata 0, resp at T+1, mem_write_enable never high.
- Backpressure: hold resp_ready = 0 for 5 cycles on an LW -> resp_valid/resp_rdata stable, req_ready = 0 throughout; a second request held valid is accepted only after the response handshake completes.
- Reset mid-RMW: assert reset in RMW_READ of SB @0x20 -> immediate IDLE, all outputs 0, no write to word 8; the next request completes normally.
